insdec_seq: RTL
===============

INSDEC_SEQ -- requirements
Module: insdec_seq

Interface
REQ-001 SHALL have parameter IW, default 8: instruction byte width in bits; legal range IW >= 8.
REQ-002 SHALL have parameter MAXB, default 4: maximum instruction length in bytes; legal range MAXB >= 3.
REQ-003 SHALL have parameter SW, default 3: width of the step-count output.
REQ-004 SHALL have derived localparam LW = $clog2(MAXB+1): width of the length output.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port byte_in, input, IW bits: instruction byte from fetch.
REQ-008 SHALL have port byte_valid, input, 1 bit: byte_in is valid.
REQ-009 SHALL have port byte_ready, output, 1 bit: block accepts a byte this cycle.
REQ-010 SHALL have port ins_bytes, output, MAXB*IW bits: assembled instruction, byte 0 (opcode) in the LSBs.
REQ-011 SHALL have port ins_len, output, LW bits: decoded instruction length in bytes.
REQ-012 SHALL have port ins_steps, output, SW bits: decoded execute micro-step count.
REQ-013 SHALL have port ins_valid, output, 1 bit: assembled instruction available.
REQ-014 SHALL have port ins_ready, input, 1 bit: consumer takes the instruction.
REQ-015 SHALL have port flush, input, 1 bit: abort the partial instruction.
REQ-016 SHALL have port resume, input, 1 bit: leave the halted state.
REQ-017 SHALL have port halted, output, 1 bit: processor halted.

Function
REQ-018 SHALL decode the opcode op with class key op[IW-1:IW-2] == 2'b11 as REG: len 1, steps 2.
REQ-019 SHALL otherwise decode on op[3:2]:
- 00 = HALT: len 1, steps 0.
- 01 = IMM: len 2, steps 4.
- 10 = DIR: len 3, steps 5.
- 11 = IND: len MAXB, steps 6.
REQ-020 SHALL implement the states IDLE, COLLECT, HOLD and HALT.
REQ-021 SHALL drive byte_ready = 1 in IDLE and COLLECT, and 0 in HOLD and HALT.
REQ-022 SHALL treat a byte as accepted only when byte_valid && byte_ready.
REQ-023 SHALL, in IDLE when a byte is accepted:
- store it as byte 0;
- clear all other bytes of ins_bytes;
- latch ins_len and ins_steps;
- go to HOLD if len == 1, else go to COLLECT with byte count 1.
REQ-024 SHALL, in COLLECT, store each accepted byte at index count and increment count.
REQ-025 SHALL go from COLLECT to HOLD in the cycle after the byte at index len-1 is accepted.
REQ-026 SHALL hold state, count and outputs unchanged in COLLECT when byte_valid is low (wait states allowed).
REQ-027 SHALL assert ins_valid only in HOLD, exactly one cycle after the final byte is accepted.
REQ-028 SHALL keep ins_bytes, ins_len and ins_steps stable while in HOLD.
REQ-029 SHALL leave HOLD on ins_valid && ins_ready: to HALT if the opcode decoded as HALT, else to IDLE.
REQ-030 SHALL assert halted only in HALT.
REQ-031 SHALL go from HALT to IDLE on resume; resume SHALL be ignored in all other states.
REQ-032 SHALL give flush priority over all inputs except reset: from IDLE, COLLECT or HOLD it returns to IDLE next cycle, clears count, drops ins_valid and accepts no byte that cycle.
REQ-033 SHALL not let flush exit HALT; only resume or reset does.
REQ-034 SHALL not accept a byte in the cycle resume takes effect, since byte_ready is 0 in HALT.

Reset
REQ-035 SHALL, on reset, clear state to IDLE, count to 0, ins_bytes, ins_len and ins_steps to 0, ins_valid to 0 and halted to 0.
REQ-036 SHALL have byte_ready = 1 in the cycle after reset.
REQ-037 SHALL give reset priority over flush, resume and all handshakes, including mid-COLLECT and in HOLD.

Structure
REQ-038 SHALL take the state enum, class and mode encodings, and the len/steps table constants from a shared package insdec_pkg.
REQ-039 SHALL place the opcode-to-{len,steps} decode in a combinational sub-module insdec_tbl, parameterised by IW, MAXB and SW.

Verification
REQ-040 SHALL cover REG: byte 0xC5 with ins_ready=1 -> ins_valid one cycle later, ins_len=1, ins_steps=2, back to IDLE.
REQ-041 SHALL cover IND with gaps: 0x0C, 0x11, 0x22, 0x33 with one idle cycle between bytes -> ins_bytes=0x3322110C, ins_len=4, ins_steps=6.
REQ-042 SHALL cover backpressure: DIR 0x08, 0xAA, 0xBB with ins_ready=0 for 5 cycles -> ins_valid held, outputs stable, byte_ready=0, then a single handoff.
REQ-043 SHALL cover halt: 0x00, then ins_ready -> halted=1 and byte_ready=0; a flush is ignored; resume -> IDLE, and the next byte 0x04 is accepted.
REQ-044 SHALL cover abort: flush after the 2nd byte of IND, and separately reset mid-COLLECT -> IDLE, count 0, no ins_valid, next opcode decodes cleanly.
REQ-045 SHALL cover parameters: MAXB=6, IW=16, opcode 0xC000 -> ins_len=1; opcode 0x000C -> ins_len=6.

Source files
------------

// File: rtl/insdec_pkg.sv
// rtl/insdec_pkg.sv - shared encodings and decode-table constants for the instruction sequencer
package insdec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_HOLD    = 2'b10,
        ST_HALT    = 2'b11
    } state_t;

    // Addressing mode carried in op[3:2] for every non-REG opcode
    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_IMM  = 2'b01,
        MODE_DIR  = 2'b10,
        MODE_IND  = 2'b11
    } mode_t;

    localparam logic [1:0] CLS_REG_KEY = 2'b11;

    localparam int LEN_REG    = 1;
    localparam int STEPS_REG  = 2;
    localparam int LEN_HALT   = 1;
    localparam int STEPS_HALT = 0;
    localparam int LEN_IMM    = 2;
    localparam int STEPS_IMM  = 4;
    localparam int LEN_DIR    = 3;
    localparam int STEPS_DIR  = 5;
    localparam int STEPS_IND  = 6;

endpackage

// File: rtl/insdec_tbl.sv
// rtl/insdec_tbl.sv - combinational opcode to {length, step count} decode
module insdec_tbl #(
    parameter int IW   = 8,
    parameter int MAXB = 4,
    parameter int SW   = 3,
    localparam int LW  = $clog2(MAXB + 1)
) (
    input  logic [IW-1:0] i_op,
    output logic [LW-1:0] o_len,
    output logic [SW-1:0] o_steps,
    output logic          o_is_halt
);
    import insdec_pkg::*;

    mode_t w_mode;
    assign w_mode = mode_t'(i_op[3:2]);

    always_comb begin
        o_len     = LW'(LEN_REG);
        o_steps   = SW'(STEPS_REG);
        o_is_halt = 1'b0;
        // REG class wins regardless of the mode bits
        if (i_op[IW-1:IW-2] != CLS_REG_KEY) begin
            unique case (w_mode)
                MODE_HALT: begin
                    o_len     = LW'(LEN_HALT);
                    o_steps   = SW'(STEPS_HALT);
                    o_is_halt = 1'b1;
                end
                MODE_IMM: begin
                    o_len   = LW'(LEN_IMM);
                    o_steps = SW'(STEPS_IMM);
                end
                MODE_DIR: begin
                    o_len   = LW'(LEN_DIR);
                    o_steps = SW'(STEPS_DIR);
                end
                MODE_IND: begin
                    o_len   = LW'(MAXB);
                    o_steps = SW'(STEPS_IND);
                end
            endcase
        end
    end

endmodule

// File: rtl/insdec_seq.sv
// rtl/insdec_seq.sv - assembles variable-length instructions from a byte stream and holds them for execute
module insdec_seq #(
    parameter int IW   = 8,
    parameter int MAXB = 4,
    parameter int SW   = 3,
    localparam int LW  = $clog2(MAXB + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IW-1:0]      byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic [MAXB*IW-1:0] ins_bytes,
    output logic [LW-1:0]      ins_len,
    output logic [SW-1:0]      ins_steps,
    output logic               ins_valid,
    input  logic               ins_ready,
    input  logic               flush,
    input  logic               resume,
    output logic               halted
);
    import insdec_pkg::*;

    state_t             r_state;
    logic [LW-1:0]      r_count;
    logic [MAXB*IW-1:0] r_bytes;
    logic [LW-1:0]      r_len;
    logic [SW-1:0]      r_steps;
    logic               r_valid;
    logic               r_halted;
    logic               r_halt_op;

    logic [LW-1:0]      w_len;
    logic [SW-1:0]      w_steps;
    logic               w_is_halt;
    logic               w_accept;

    insdec_tbl #(.IW(IW), .MAXB(MAXB), .SW(SW)) u_tbl (
        .i_op      (byte_in),
        .o_len     (w_len),
        .o_steps   (w_steps),
        .o_is_halt (w_is_halt)
    );

    assign byte_ready = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
    assign w_accept   = byte_valid && byte_ready;
    assign ins_bytes  = r_bytes;
    assign ins_len    = r_len;
    assign ins_steps  = r_steps;
    assign ins_valid  = r_valid;
    assign halted     = r_halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_bytes   <= '0;
            r_len     <= '0;
            r_steps   <= '0;
            r_valid   <= 1'b0;
            r_halted  <= 1'b0;
            r_halt_op <= 1'b0;
        end else if (flush && r_state != ST_HALT) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_bytes   <= {{((MAXB-1)*IW){1'b0}}, byte_in};
                    r_len     <= w_len;
                    r_steps   <= w_steps;
                    r_halt_op <= w_is_halt;
                    if (w_len == LW'(1)) begin
                        r_state <= ST_HOLD;
                        r_valid <= 1'b1;
                        r_count <= '0;
                    end else begin
                        r_state <= ST_COLLECT;
                        r_count <= LW'(1);
                    end
                end
                ST_COLLECT: if (w_accept) begin
                    r_bytes[IW*int'(r_count) +: IW] <= byte_in;
                    r_count <= r_count + LW'(1);
                    if (r_count == r_len - LW'(1)) begin
                        r_state <= ST_HOLD;
                        r_valid <= 1'b1;
                    end
                end
                ST_HOLD: if (ins_ready) begin
                    r_valid <= 1'b0;
                    r_count <= '0;
                    if (r_halt_op) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HALT: if (resume) begin
                    r_state  <= ST_IDLE;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

endmodule
